// File: rtl/skid_fifo.sv
// skid_fifo: FIFO whose valid, ready and data outputs all come straight from flops.
// Defining SKID_FIFO_LEVEL_EN adds the registered level_o entry-count output.
module skid_fifo #(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned DEPTH     = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_clk_i,
  input  logic                       flush_i,
  input  logic [DATA_SIZE-1:0]       data_i,
  input  logic                       data_valid_i,
  output logic                       data_ready_o,
  output logic [DATA_SIZE-1:0]       data_o,
  output logic                       data_valid_o,
  input  logic                       data_ready_i
`ifdef SKID_FIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] level_o
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [PTR_W-1:0]     wptr_q, wptr_d;
  logic [PTR_W-1:0]     rptr_q, rptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_SIZE-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ready_q, ready_d;
  logic [DATA_SIZE-1:0] mem_q [DEPTH];

  logic push_c;
  logic pop_c;

  assign push_c = data_valid_i && ready_q;
  assign pop_c  = valid_q && data_ready_i;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Next-state, pointer, count and output-register computation.
  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
      wptr_d  = '0;
      rptr_d  = '0;
      cnt_d   = '0;
    end else begin
      if (push_c) wptr_d = ptr_inc(wptr_q);
      if (pop_c)  rptr_d = ptr_inc(rptr_q);
      unique case (state_q)
        ST_EMPTY: begin
          if (push_c) begin
            state_d = ST_PARTIAL;
            cnt_d   = CNT_ONE;
          end
        end
        ST_PARTIAL: begin
          if (push_c && !pop_c) begin
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) state_d = ST_FULL;
          end else if (pop_c && !push_c) begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop_c) begin
            state_d = ST_PARTIAL;
            cnt_d   = cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          wptr_d  = '0;
          rptr_d  = '0;
          cnt_d   = '0;
        end
      endcase
      // Head word is the incoming one when it lands in the slot the read pointer moves to.
      if (state_d != ST_EMPTY) begin
        data_d = (push_c && (rptr_d == wptr_q)) ? data_i : mem_q[rptr_d];
      end
    end
    valid_d = (state_d != ST_EMPTY);
    ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clk_i or posedge rst_clk_i) begin
    if (rst_clk_i) begin
      state_q <= ST_EMPTY;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  // Storage array is intentionally left unreset.
  always_ff @(posedge clk_i) begin
    if (push_c && !flush_i) mem_q[wptr_q] <= data_i;
  end

  assign data_ready_o = ready_q;
  assign data_valid_o = valid_q;
  assign data_o       = data_q;

`ifdef SKID_FIFO_LEVEL_EN
  assign level_o = cnt_q;
`endif

  a_cnt_bound : assert property (@(posedge clk_i) disable iff (rst_clk_i) cnt_q <= CNT_FULL);
  a_no_push_full : assert property (@(posedge clk_i) disable iff (rst_clk_i)
    (state_q == ST_FULL) |-> !push_c);

endmodule

// File: tb/tb_skid_fifo.sv
// Directed-vector bench for skid_fifo at DEPTH 2, 3 and 5.
// Level checks are active when SKID_FIFO_LEVEL_EN is defined.
module tb_skid_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       vin = 1'b0;
  logic       rdy = 1'b0;
  logic [7:0] din = 8'h00;

  logic       r2, v2, r3, v3, r5, v5;
  logic [7:0] d2, d3, d5;
`ifdef SKID_FIFO_LEVEL_EN
  logic [1:0] l2, l3;
  logic [2:0] l5;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  skid_fifo #(.DATA_SIZE(8), .DEPTH(2)) u2 (
    .clk_i(clk), .rst_clk_i(rst), .flush_i(flush), .data_i(din), .data_valid_i(vin),
    .data_ready_o(r2), .data_o(d2), .data_valid_o(v2), .data_ready_i(rdy)
`ifdef SKID_FIFO_LEVEL_EN
    , .level_o(l2)
`endif
  );

  skid_fifo #(.DATA_SIZE(8), .DEPTH(3)) u3 (
    .clk_i(clk), .rst_clk_i(rst), .flush_i(flush), .data_i(din), .data_valid_i(vin),
    .data_ready_o(r3), .data_o(d3), .data_valid_o(v3), .data_ready_i(rdy)
`ifdef SKID_FIFO_LEVEL_EN
    , .level_o(l3)
`endif
  );

  skid_fifo #(.DATA_SIZE(8), .DEPTH(5)) u5 (
    .clk_i(clk), .rst_clk_i(rst), .flush_i(flush), .data_i(din), .data_valid_i(vin),
    .data_ready_o(r5), .data_o(d5), .data_valid_o(v5), .data_ready_i(rdy)
`ifdef SKID_FIFO_LEVEL_EN
    , .level_o(l5)
`endif
  );

  typedef struct {
    logic       flush;
    logic       vin;
    logic [7:0] din;
    logic       rdy;
    logic       ev;
    logic       er;
    logic [7:0] ed;
    int         el;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    flush = 1'b0;
    vin   = 1'b0;
    rdy   = 1'b0;
    rst   = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    byte unsigned q[$];
    byte unsigned next_val;
    logic         push_m, pop_m;

    // flush vin din rdy | valid ready data level
    vt[0]  = '{1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 8'h01, 1};
    vt[1]  = '{1'b0, 1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 8'h01, 2};
    vt[2]  = '{1'b0, 1'b1, 8'h03, 1'b0, 1'b1, 1'b0, 8'h01, 3};
    vt[3]  = '{1'b0, 1'b1, 8'h04, 1'b0, 1'b1, 1'b0, 8'h01, 3};
    vt[4]  = '{1'b0, 1'b1, 8'h04, 1'b1, 1'b1, 1'b1, 8'h02, 2};
    vt[5]  = '{1'b0, 1'b1, 8'h04, 1'b1, 1'b1, 1'b1, 8'h03, 2};
    vt[6]  = '{1'b0, 1'b1, 8'h05, 1'b1, 1'b1, 1'b1, 8'h04, 2};
    vt[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h05, 1};
    vt[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 0};
    vt[9]  = '{1'b0, 1'b1, 8'h06, 1'b1, 1'b1, 1'b1, 8'h06, 1};
    vt[10] = '{1'b0, 1'b1, 8'h07, 1'b1, 1'b1, 1'b1, 8'h07, 1};
    vt[11] = '{1'b0, 1'b1, 8'h08, 1'b0, 1'b1, 1'b1, 8'h07, 2};
    vt[12] = '{1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 8'h00, 0};
    vt[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 0};
    vt[14] = '{1'b0, 1'b1, 8'h09, 1'b1, 1'b1, 1'b1, 8'h09, 1};
    vt[15] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 0};

    // Asynchronous reset state before any clock edge
    #2;
    chk("rst_valid3", 32'(v3), 0);
    chk("rst_ready3", 32'(r3), 0);
    chk("rst_data3", 32'(d3), 0);
    chk("rst_ready2", 32'(r2), 0);
    chk("rst_data5", 32'(d5), 0);
`ifdef SKID_FIFO_LEVEL_EN
    chk("rst_level3", 32'(l3), 0);
`endif
    tick();
    rst = 1'b0;
    #2;
    chk("ready_before_edge", 32'(r3), 0);
    tick();
    chk("ready_first_edge", 32'(r3), 1);
    chk("valid_first_edge", 32'(v3), 0);

    // Table-driven DEPTH=3 sequence: fill, stall, full-pop, stream, flush
    for (int i = 0; i < 16; i++) begin
      flush = vt[i].flush;
      vin   = vt[i].vin;
      din   = vt[i].din;
      rdy   = vt[i].rdy;
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(v3), 32'(vt[i].ev));
      chk($sformatf("vec%0d_ready", i), 32'(r3), 32'(vt[i].er));
      if (vt[i].ev) chk($sformatf("vec%0d_data", i), 32'(d3), 32'(vt[i].ed));
      if (v3 && d3 == 8'h77) chk("flushed_word_seen", 32'(d3), 0);
`ifdef SKID_FIFO_LEVEL_EN
      chk($sformatf("vec%0d_level", i), 32'(l3), 32'(vt[i].el));
`endif
    end
    flush = 1'b0;

    // DEPTH=2 single-word latency
    do_reset();
    vin = 1'b1; din = 8'hA5; rdy = 1'b1;
    tick();
    chk("d2_valid", 32'(v2), 1);
    chk("d2_data", 32'(d2), 32'h A5);
    vin = 1'b0;
    tick();
    chk("d2_empty_again", 32'(v2), 0);
    chk("d2_ready", 32'(r2), 1);
`ifdef SKID_FIFO_LEVEL_EN
    chk("d2_level", 32'(l2), 0);
`endif

    // Mid-operation asynchronous reset with two entries stored
    do_reset();
    vin = 1'b1; rdy = 1'b0; din = 8'h11;
    tick();
    din = 8'h22;
    tick();
    vin = 1'b0;
    chk("midrst_pre_valid", 32'(v3), 1);
    #3 rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(v3), 0);
    chk("midrst_ready", 32'(r3), 0);
    chk("midrst_data", 32'(d3), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("midrst_ready_held", 32'(r3), 0);
    tick();
    chk("midrst_ready_rise", 32'(r3), 1);
    chk("midrst_discard", 32'(v3), 0);

    // DEPTH=5 random-stall stream against a queue model
    do_reset();
    next_val = 8'h01;
    q.delete();
    for (int c = 0; c < 70; c++) begin
      vin = (c < 60) ? ($urandom_range(0, 3) != 0) : 1'b0;
      rdy = (c < 25) ? ($urandom_range(0, 3) == 0) : (($urandom_range(0, 2) != 0) || c >= 60);
      din = next_val;
      push_m = vin && (q.size() != 5);
      pop_m  = rdy && (q.size() != 0);
      tick();
      if (pop_m) void'(q.pop_front());
      if (push_m) begin
        q.push_back(next_val);
        next_val++;
      end
      chk($sformatf("s5_ready_%0d", c), 32'(r5), 32'(q.size() != 5));
      chk($sformatf("s5_valid_%0d", c), 32'(v5), 32'(q.size() != 0));
      if (q.size() != 0) chk($sformatf("s5_data_%0d", c), 32'(d5), 32'(q[0]));
`ifdef SKID_FIFO_LEVEL_EN
      chk($sformatf("s5_level_%0d", c), 32'(l5), 32'(q.size()));
`endif
    end
    chk("s5_drained", 32'(v5), 0);
    vin = 1'b0;
    rdy = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/skid_fifo.md
SKID_FIFO -- requirements
Module: skid_fifo

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 8, payload width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 2, storage entries (>=2, any integer, power of two not required).
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk_i  input  1  sole clock, rising edge.
REQ-005 rst_clk_i  input  1  asynchronous active-high reset.
REQ-006 flush_i  input  1  synchronous flush, drops all stored entries.
REQ-007 data_i  input  DATA_SIZE  upstream payload.
REQ-008 data_valid_i  input  1  upstream valid.
REQ-009 data_ready_o  output  1  upstream ready, driven directly from a flop.
REQ-010 data_o  output  DATA_SIZE  downstream payload, driven directly from a flop.
REQ-011 data_valid_o  output  1  downstream valid, driven directly from a flop.
REQ-012 data_ready_i  input  1  downstream ready.
REQ-013 level_o  output  $clog2(DEPTH+1)  stored entry count; present only under SKID_FIFO_LEVEL_EN.

Function
REQ-014 Push SHALL occur when data_valid_i && data_ready_o; pop SHALL occur when data_valid_o && data_ready_i.
REQ-015 No combinational path SHALL exist from any input to any output.
REQ-016 State SHALL be EMPTY (count 0), PARTIAL (0<count<DEPTH) or FULL (count DEPTH); data_valid_o = state!=EMPTY, data_ready_o = state!=FULL.
REQ-017 Transitions: push only -> count+1; pop only -> count-1; push and pop -> count unchanged; neither -> unchanged.
REQ-018 EMPTY->PARTIAL on push; PARTIAL->FULL on push-only at count DEPTH-1; FULL->PARTIAL on pop; PARTIAL->EMPTY on pop-only at count 1.
REQ-019 Latency: a word pushed into EMPTY at edge N SHALL appear on data_o with data_valid_o=1 after edge N (one cycle).
REQ-020 Order SHALL be strict FIFO; data_o SHALL equal the oldest stored word whenever data_valid_o=1.
REQ-021 Read and write pointers SHALL wrap from DEPTH-1 to 0.
REQ-022 In FULL, simultaneous pop SHALL NOT accept input that cycle (data_ready_o already 0); data_ready_o rises the following cycle.
REQ-023 In PARTIAL, simultaneous push and pop SHALL keep count and advance both pointers.
REQ-024 data_o and data_valid_o SHALL hold stable while data_valid_o=1 and data_ready_i=0.
REQ-025 flush_i=1 at an edge SHALL force count 0, both pointers 0, state EMPTY; any push that cycle SHALL be discarded; a pop that cycle is a completed transfer.
REQ-026 data_o value while data_valid_o=0 is don't-care but SHALL NOT be X after reset.
REQ-027 Arithmetic SHALL be unsigned; count SHALL never exceed DEPTH nor underflow.

Reset
REQ-028 Asserting rst_clk_i SHALL immediately (asynchronously) force state EMPTY, pointers 0, data_valid_o=0, data_ready_o=0, data_o=0, level_o=0.
REQ-029 data_ready_o SHALL rise to 1 on the first clock edge after rst_clk_i deasserts.
REQ-030 Reset mid-operation SHALL discard all stored entries; no partial transfer completes.
REQ-031 Storage array contents need not be reset.

Configuration
REQ-032 Macro SKID_FIFO_LEVEL_EN defined: level_o port present, registered, equal to count, updated on the same edge as state.
REQ-033 Macro SKID_FIFO_LEVEL_EN undefined: level_o port absent; all other behaviour identical.

Verification
REQ-034 DEPTH=2, push 0xA5 into EMPTY with data_ready_i=1 -> data_o=0xA5, data_valid_o=1 exactly one cycle later, then EMPTY again.
REQ-035 DEPTH=3, data_ready_i=0, push 0x01,0x02,0x03 -> data_ready_o=0 after third push, level_o=3; fourth word 0x04 held on data_i not accepted.
REQ-036 DEPTH=3 FULL, data_ready_i=1 for 3 cycles while driving 0x04.. -> outputs 0x01,0x02,0x03 in order, 0x04 accepted one cycle after first pop, no loss or duplicate.
REQ-037 DEPTH=5, 20 random-stall push/pop cycles -> pointer wrap exercised, output sequence equals input sequence, level_o never >5.
REQ-038 count=2, flush_i=1 with concurrent push of 0x77 -> next cycle data_valid_o=0, level_o=0, 0x77 never appears on data_o.
REQ-039 count=2, assert rst_clk_i between edges -> data_valid_o=0 and data_ready_o=0 before next edge; data_ready_o=1 on first edge after release.
